// File: rtl/motor_step_decoder_pkg.sv
// Shared encodings for the step/dir decoder and the motor_step_gen benches.
package motor_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_HOLD = 2'd2
  } step_state_e;

  localparam int ERR_W     = 3;
  localparam int ERR_SETUP = 0;
  localparam int ERR_WIDTH = 1;
  localparam int ERR_HOLD  = 2;

endpackage

// File: rtl/motor_step_decoder_if.sv
// Pins, limits and results of motor_step_decoder; master drives pins, slave is the decoder.
// The period signal exists only when STEP_DEC_PERIOD_EN is defined.
interface motor_step_decoder_if #(
  parameter int POS_W = 32,
  parameter int CNT_W = 16
) ();

  logic             step_in;
  logic             dir_in;
  logic [CNT_W-1:0] pre_n;
  logic [CNT_W-1:0] pulse_n;
  logic [CNT_W-1:0] post_n;
  logic             set_pos;
  logic [POS_W-1:0] pos_val;
  logic             clear_err;
  logic             step_stb;
  logic             step_dir;
  logic [POS_W-1:0] position;
  logic [2:0]       err;
  logic             busy;
`ifdef STEP_DEC_PERIOD_EN
  logic [CNT_W-1:0] period;
`endif

  modport master (
    output step_in, dir_in, pre_n, pulse_n, post_n, set_pos, pos_val, clear_err,
    input  step_stb, step_dir, position, err, busy
`ifdef STEP_DEC_PERIOD_EN
    , input period
`endif
  );

  modport slave (
    input  step_in, dir_in, pre_n, pulse_n, post_n, set_pos, pos_val, clear_err,
    output step_stb, step_dir, position, err, busy
`ifdef STEP_DEC_PERIOD_EN
    , output period
`endif
  );

endinterface

// File: rtl/motor_step_decoder_sync.sv
// Two-flop synchroniser for an asynchronous pin plus the previous synced sample for edge detect.
module step_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o,
  output logic prev_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_o = sync_q;
  assign prev_o = prev_q;

endmodule

// File: rtl/motor_step_decoder.sv
// Step/dir receiver: counts steps into a signed position and flags setup/width/hold violations.
// step_stb appears on the 3rd clk edge sampling step_in high; STEP_DEC_PERIOD_EN adds period.
module motor_step_decoder
  import motor_step_pkg::*;
#(
  parameter int POS_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  motor_step_decoder_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   LEN_ONE = (CNT_W+1)'(1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic step_s, step_p;
  logic dir_s, dir_p;

  step_sync u_step_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (bus.step_in),
    .sync_o  (step_s),
    .prev_o  (step_p)
  );

  step_sync u_dir_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (bus.dir_in),
    .sync_o  (dir_s),
    .prev_o  (dir_p)
  );

  logic step_rise, step_fall, dir_chg;

  assign step_rise = step_s & ~step_p;
  assign step_fall = ~step_s & step_p;
  assign dir_chg   = dir_s ^ dir_p;

  step_state_e      state_q, state_d;
  logic [CNT_W-1:0] dir_cnt_q, dir_cnt_d, dir_cnt_now;
  logic [CNT_W-1:0] wid_cnt_q, wid_cnt_d;
  logic [CNT_W-1:0] hld_cnt_q, hld_cnt_d;
  logic [POS_W-1:0] position_q, position_d;
  logic [ERR_W-1:0] err_q, err_d, err_new;
  logic             step_stb_q, step_stb_d;
  logic             step_dir_q, step_dir_d;
  logic [CNT_W:0]   wid_len, hld_len;

  // A change seen in this very cycle counts as zero stable cycles, so a dir
  // edge coincident with a step rise is a setup violation.
  always_comb begin
    dir_cnt_now = dir_chg ? '0 : dir_cnt_q;
    dir_cnt_d   = sat_inc(dir_cnt_now);
  end

  assign wid_len = {1'b0, wid_cnt_q} + LEN_ONE;
  assign hld_len = {1'b0, hld_cnt_q} + LEN_ONE;

  always_comb begin
    state_d    = state_q;
    wid_cnt_d  = sat_inc(wid_cnt_q);
    hld_cnt_d  = sat_inc(hld_cnt_q);
    err_new    = '0;
    step_stb_d = 1'b0;
    step_dir_d = step_dir_q;
    position_d = position_q;

    unique case (state_q)
      ST_IDLE: begin
        if (step_rise) begin
          state_d   = ST_HIGH;
          wid_cnt_d = '0;
        end
      end
      ST_HIGH: begin
        if (dir_chg) begin
          err_new[ERR_SETUP] = 1'b1;
        end
        if (step_fall) begin
          if (wid_len < {1'b0, bus.pulse_n}) begin
            err_new[ERR_WIDTH] = 1'b1;
          end
          state_d   = ST_HOLD;
          hld_cnt_d = '0;
        end
      end
      ST_HOLD: begin
        if (dir_chg) begin
          err_new[ERR_HOLD] = 1'b1;
        end
        if (step_rise) begin
          err_new[ERR_HOLD] = 1'b1;
          state_d           = ST_HIGH;
          wid_cnt_d         = '0;
        end else if (hld_len >= {1'b0, bus.post_n}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Timing errors only flag; every rise is still counted.
    if (step_rise) begin
      step_stb_d = 1'b1;
      step_dir_d = dir_s;
      position_d = dir_s ? (position_q + POS_ONE) : (position_q - POS_ONE);
      if (dir_cnt_now < bus.pre_n) begin
        err_new[ERR_SETUP] = 1'b1;
      end
    end

    if (bus.set_pos) begin
      position_d = bus.pos_val;
    end

    err_d = (err_q & ~{ERR_W{bus.clear_err}}) | err_new;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      dir_cnt_q  <= CNT_MAX;
      wid_cnt_q  <= '0;
      hld_cnt_q  <= '0;
      position_q <= '0;
      err_q      <= '0;
      step_stb_q <= 1'b0;
      step_dir_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_cnt_q  <= dir_cnt_d;
      wid_cnt_q  <= wid_cnt_d;
      hld_cnt_q  <= hld_cnt_d;
      position_q <= position_d;
      err_q      <= err_d;
      step_stb_q <= step_stb_d;
      step_dir_q <= step_dir_d;
    end
  end

  assign bus.step_stb = step_stb_q;
  assign bus.step_dir = step_dir_q;
  assign bus.position = position_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != ST_IDLE);

`ifdef STEP_DEC_PERIOD_EN
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;

  // per_cnt starts saturated so the first rise after reset reports the maximum.
  always_comb begin
    per_cnt_d = step_rise ? CNT_ONE : sat_inc(per_cnt_q);
    period_d  = step_rise ? per_cnt_q : period_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_cnt_q <= CNT_MAX;
      period_q  <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
    end
  end

  assign bus.period = period_q;
`endif

endmodule
